// File: rtl/bitwise_logic_iter_pkg.sv
// Shared definitions for the iterative bitwise logic unit.
// Op encodings are also used by the execute-stage decoder.
// Holds no logic, so latency and backpressure do not apply.
package bitwise_logic_iter_pkg;

    localparam logic [1:0] LOP_AND = 2'b00;
    localparam logic [1:0] LOP_OR  = 2'b01;
    localparam logic [1:0] LOP_XOR = 2'b10;
    localparam logic [1:0] LOP_NOR = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Slice counter width; a single-slice configuration still needs one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bitwise_logic_iter_slice_logic.sv
// Combinational AND/OR/XOR/NOR cell operating on one SLICE-bit slice.
// Latency: zero cycles.
// Backpressure: none; the output simply follows the inputs.
module slice_logic
    import bitwise_logic_iter_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [1:0]       op,
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    output logic [SLICE-1:0] z
);

    always_comb begin
        z = '0;
        case (op)
            LOP_AND: z = x & y;
            LOP_OR:  z = x | y;
            LOP_XOR: z = x ^ y;
            LOP_NOR: z = ~(x | y);
        endcase
    end

endmodule

// File: rtl/bitwise_logic_iter.sv
// Multi-cycle bitwise logic unit: processes SLICE bits per cycle, LSB slice first.
// Latency: done pulses WIDTH/SLICE cycles after the edge that samples start.
// Backpressure: busy is high while running; start is ignored until busy drops.
module bitwise_logic_iter
    import bitwise_logic_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int NSLC = WIDTH / SLICE;
    localparam int CW   = cnt_width(NSLC);

    generate
        if (SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_bad_cfg
            $error("bitwise_logic_iter: WIDTH must be a non-zero multiple of SLICE");
        end
    endgenerate

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic [CW-1:0]    count;
    logic             last;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;
    logic             nonzero;
    logic [SLICE-1:0] x_sl;
    logic [SLICE-1:0] y_sl;
    logic [SLICE-1:0] z_sl;

    assign last = (count == CW'(NSLC - 1));
    assign busy = (state == ST_RUN);
    assign x_sl = a_q[32'(count) * SLICE +: SLICE];
    assign y_sl = b_q[32'(count) * SLICE +: SLICE];

    slice_logic #(
        .SLICE (SLICE)
    ) u_slice (
        .op (op_q),
        .x  (x_sl),
        .y  (y_sl),
        .z  (z_sl)
    );

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    accept    = 1'b1;
                end
            end
            ST_RUN: begin
                if (last) begin
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // zero is derived from a sticky flag so the result register never needs a wide OR-reduce.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= LOP_AND;
            count   <= '0;
            nonzero <= 1'b0;
            result  <= '0;
            zero    <= 1'b1;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_q     <= a;
                b_q     <= b;
                op_q    <= op;
                count   <= '0;
                nonzero <= 1'b0;
            end else if (state == ST_RUN) begin
                result[32'(count) * SLICE +: SLICE] <= z_sl;
                nonzero <= nonzero | (|z_sl);
                if (last) begin
                    count <= '0;
                    done  <= 1'b1;
                    zero  <= ~(nonzero | (|z_sl));
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bitwise_logic_iter.sv
// Scoreboard bench for bitwise_logic_iter at SLICE = 8, 32 and 1.
// Expected result/zero/done-cycle are queued at issue and popped on each done pulse.
module tb_bitwise_logic_iter;
    import bitwise_logic_iter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [2:0]  zero;
    logic [31:0] res0;
    logic [31:0] res1;
    logic [31:0] res2;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] r;
        logic        z;
        int          t;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bitwise_logic_iter u_dut8 (
        .clk(clk), .rst(rst), .start(start[0]), .op(op), .a(a), .b(b),
        .busy(busy[0]), .done(done[0]), .result(res0), .zero(zero[0])
    );

    bitwise_logic_iter #(.WIDTH(32), .SLICE(32)) u_dut32 (
        .clk(clk), .rst(rst), .start(start[1]), .op(op), .a(a), .b(b),
        .busy(busy[1]), .done(done[1]), .result(res1), .zero(zero[1])
    );

    bitwise_logic_iter #(.WIDTH(32), .SLICE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[2]), .op(op), .a(a), .b(b),
        .busy(busy[2]), .done(done[2]), .result(res2), .zero(zero[2])
    );

    function automatic int ns(input int w);
        case (w)
            0:       return 4;
            1:       return 1;
            default: return 32;
        endcase
    endfunction

    // Whole-word reference: the slicing must be invisible at the result.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        case (o)
            LOP_AND: return x & y;
            LOP_OR:  return x | y;
            LOP_XOR: return x ^ y;
            default: return ~(x | y);
        endcase
    endfunction

    function automatic int qsize(input int w);
        case (w)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int w, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int t);
        exp_t e;
        e.r = model(o, x, y);
        e.z = (e.r == 32'd0);
        e.t = t;
        case (w)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_check(input int w, input logic [31:0] r, input logic z);
        exp_t e;
        bit   have;
        have = 1'b0;
        case (w)
            0:       if (q0.size() != 0) begin e = q0.pop_front(); have = 1'b1; end
            1:       if (q1.size() != 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() != 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            n_chk++;
            n_fail++;
            $display("FAIL spurious_done[%0d]: got done=1 expected no done (cycle %0d)", w, cyc);
        end else begin
            check($sformatf("result[%0d]", w), r, e.r);
            check($sformatf("zero[%0d]", w), 32'(z), 32'(e.z));
            check($sformatf("done_cycle[%0d]", w), 32'(cyc), 32'(e.t));
        end
    endtask

    always @(negedge clk) begin
        if (done[0]) pop_check(0, res0, zero[0]);
        if (done[1]) pop_check(1, res1, zero[1]);
        if (done[2]) pop_check(2, res2, zero[2]);
    end

    task automatic issue(input int w, input logic [31:0] x, input logic [31:0] y, input logic [1:0] o);
        @(negedge clk);
        a = x;
        b = y;
        op = o;
        start[w] = 1'b1;
        @(posedge clk);
        #1;
        push(w, o, x, y, cyc + ns(w));
        check($sformatf("busy_after_start[%0d]", w), 32'(busy[w]), 32'd1);
        start[w] = 1'b0;
    endtask

    // Hammers start and operands on every RUN edge; all of it must be ignored.
    task automatic noise(input int w);
        repeat (ns(w)) begin
            start[w] = 1'b1;
            a = $urandom;
            b = $urandom;
            op = 2'($urandom_range(3));
            @(posedge clk);
            #1;
        end
        start[w] = 1'b0;
    endtask

    task automatic wait_idle(input int w);
        for (int k = 0; k < 200; k++) begin
            if (qsize(w) == 0) break;
            @(negedge clk);
        end
        if (qsize(w) != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout[%0d]: got %0d pending expected 0", w, qsize(w));
            case (w)
                0:       q0.delete();
                1:       q1.delete();
                default: q2.delete();
            endcase
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_zero"}, 32'(zero), 32'd7);
        check({tag, "_result0"}, res0, 32'd0);
        check({tag, "_result1"}, res1, 32'd0);
        check({tag, "_result2"}, res2, 32'd0);
    endtask

    task automatic run_random(input int w, input int n);
        logic [31:0] x;
        logic [31:0] y;
        logic [1:0]  o;
        for (int i = 0; i < n; i++) begin
            x = $urandom;
            case ($urandom_range(3))
                0:       y = x;
                1:       y = ~x;
                default: y = $urandom;
            endcase
            o = 2'($urandom_range(3));
            issue(w, x, y, o);
            if ($urandom_range(1) == 1) noise(w);
            wait_idle(w);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected completion (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        start = 3'b000;
        op = 2'b00;
        a = '0;
        b = '0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_reset_outputs("idle");

        // Reference XOR vector on all three slice widths.
        for (int w = 0; w < 3; w++) begin
            issue(w, 32'hDEADBEEF, 32'hFFFF0000, LOP_XOR);
            wait_idle(w);
        end
        repeat (3) @(negedge clk);
        check("result_held", res0, 32'h2152BEEF);
        check("busy_idle_after_done", 32'(busy[0]), 32'd0);

        issue(0, 32'hFFFFFFFF, 32'h00000000, LOP_NOR);
        wait_idle(0);
        issue(0, 32'hF0F0F0F0, 32'h0F0F0F0F, LOP_AND);
        wait_idle(0);

        issue(0, 32'hDEADBEEF, 32'hFFFF0000, LOP_XOR);
        noise(0);
        wait_idle(0);

        // Start held high: the second op is taken on the edge where done is showing.
        @(negedge clk);
        a = 32'd1;
        b = 32'd2;
        op = LOP_OR;
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        push(0, LOP_OR, 32'd1, 32'd2, cyc + ns(0));
        repeat (ns(0)) @(posedge clk);
        #1;
        a = 32'd0;
        b = 32'd0;
        @(posedge clk);
        #1;
        push(0, LOP_OR, 32'd0, 32'd0, cyc + ns(0));
        start[0] = 1'b0;
        wait_idle(0);

        // Asynchronous reset in the middle of a run discards the operation.
        issue(0, 32'h12345678, 32'h0F0F0F0F, LOP_OR);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrun_reset");
        q0.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        issue(0, 32'hA5A5A5A5, 32'h0000FFFF, LOP_XOR);
        wait_idle(0);

        run_random(0, 20);
        run_random(1, 10);
        run_random(2, 4);
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
